// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a single-outstanding instruction bus and produces the registered decode bundle.
// dataF = {valid, pc[XLEN-1:0], instr[31:0], error[1:0]}; error codes NOERROR=0, EFETCH=1, EMISALIGN=2.
module fetch_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stopd,
  input  logic              stope,
  input  logic              stopm,
  input  logic              branch,
  input  logic [XLEN-1:0]   branch_target,
  output logic              ireq_valid,
  output logic [XLEN-1:0]   ireq_addr,
  input  logic              iresp_ok,
  input  logic [31:0]       iresp_data,
  input  logic              iresp_err,
  output logic [XLEN+34:0]  dataF
);

  localparam logic [1:0] NOERROR   = 2'd0;
  localparam logic [1:0] EFETCH    = 2'd1;
  localparam logic [1:0] EMISALIGN = 2'd2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              out_vld_q, out_vld_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [1:0]        out_err_q, out_err_d;
  logic [31:0]       buf_instr_q, buf_instr_d;
  logic              buf_err_q, buf_err_d;

  logic              stall;
  logic              misaligned;
  logic              req_live;
  logic [XLEN-1:0]   pc_inc;

  assign stall      = stopd | stope | stopm;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign pc_inc     = pc_q + XLEN'(4);

  // DRAIN keeps presenting the pre-redirect address so the bus sees a stable request.
  assign req_live   = ((state_q == FETCH) && !misaligned) || (state_q == DRAIN);
  assign ireq_valid = reset & req_live;
  assign ireq_addr  = (state_q == DRAIN) ? addr_q : pc_q;
  assign dataF      = {out_vld_q, out_pc_q, out_instr_q, out_err_q};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    out_vld_d   = out_vld_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    buf_instr_d = buf_instr_q;
    buf_err_d   = buf_err_q;

    case (state_q)
      FETCH: begin
        addr_d = pc_q;
        if (branch) begin
          pc_d      = branch_target;
          out_vld_d = 1'b0;
          state_d   = (req_live && !iresp_ok) ? DRAIN : FETCH;
        end else if (misaligned) begin
          if (!stall) begin
            out_vld_d   = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = 32'h0;
            out_err_d   = EMISALIGN;
          end
        end else if (iresp_ok) begin
          if (!stall) begin
            out_vld_d   = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = iresp_data;
            out_err_d   = iresp_err ? EFETCH : NOERROR;
            pc_d        = pc_inc;
          end else begin
            buf_instr_d = iresp_data;
            buf_err_d   = iresp_err;
            state_d     = HOLD;
          end
        end else if (!stall) begin
          out_vld_d = 1'b0;
        end
      end

      HOLD: begin
        if (branch) begin
          pc_d      = branch_target;
          out_vld_d = 1'b0;
          state_d   = FETCH;
        end else if (!stall) begin
          out_vld_d   = 1'b1;
          out_pc_d    = pc_q;
          out_instr_d = buf_instr_q;
          out_err_d   = buf_err_q ? EFETCH : NOERROR;
          pc_d        = pc_inc;
          state_d     = FETCH;
        end
      end

      DRAIN: begin
        out_vld_d = 1'b0;
        if (branch) begin
          pc_d = branch_target;
        end
        // A completing response always ends the drain, even alongside a newer redirect.
        if (iresp_ok) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d   = FETCH;
        out_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      out_vld_q   <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= 32'h0;
      out_err_q   <= NOERROR;
      buf_instr_q <= 32'h0;
      buf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      out_vld_q   <= out_vld_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      buf_instr_q <= buf_instr_d;
      buf_err_q   <= buf_err_d;
    end
  end

endmodule
